// File: rtl/mips_md_pkg.sv
// Shared types, widths and sign helpers for the HI/LO multiply/divide engine.
package mips_md_pkg;

    localparam int unsigned MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MULT  = 2'd0,
        MULTU = 2'd1,
        DIV   = 2'd2,
        DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic [MD_WIDTH-1:0] md_neg(input logic [MD_WIDTH-1:0] x);
        return ~x + MD_WIDTH'(1);
    endfunction

    function automatic logic [MD_WIDTH-1:0] md_abs(input logic [MD_WIDTH-1:0] x);
        return x[MD_WIDTH-1] ? md_neg(x) : x;
    endfunction

    // Full-product negation, modulo 2*MD_WIDTH.
    function automatic logic [2*MD_WIDTH-1:0] md_neg_wide(input logic [2*MD_WIDTH-1:0] x);
        return ~x + (2*MD_WIDTH)'(1);
    endfunction

endpackage

// File: rtl/mult_div_engine.sv
// Iterative one-bit-per-cycle MULT/MULTU/DIV/DIVU engine feeding the HI/LO registers.
module mult_div_engine
    import mips_md_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    input  logic               flush,
    output logic               busy,
    output logic               write,
    output logic [2*WIDTH-1:0] write_data
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    md_state_t          state, state_next;
    md_op_t             op_q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_q, neg_r, div_zero;

    logic               accept, last, is_div;
    logic               signed_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   quot, rem;
    logic [2*WIDTH-1:0] result;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        write      = 1'b0;
        unique case (state)
            IDLE: if (start && !flush) state_next = CALC;
            CALC: begin
                busy = 1'b1;
                if (flush)     state_next = IDLE;
                else if (last) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                write      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept    = (state == IDLE) && start && !flush;
    assign last      = (cnt == CNT_W'(WIDTH-1));
    assign is_div    = (op_q == DIV) || (op_q == DIVU);
    assign signed_op = ~op[0];
    assign mag_a     = signed_op ? md_abs(src_a) : src_a;
    assign mag_b     = signed_op ? md_abs(src_b) : src_b;

    // Multiply: acc = {partial hi, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (is_div)
            acc_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        else
            acc_next = {mul_sum, acc[WIDTH-1:1]};

        quot = neg_q ? md_neg(acc_next[WIDTH-1:0]) : acc_next[WIDTH-1:0];
        rem  = neg_r ? md_neg(acc_next[2*WIDTH-1:WIDTH]) : acc_next[2*WIDTH-1:WIDTH];
        if (!is_div)
            result = neg_q ? md_neg_wide(acc_next) : acc_next;
        else if (div_zero)
            result = {opnd, {WIDTH{1'b1}}};
        else
            result = {rem, quot};
    end

    // Divide-by-zero keeps the raw dividend in opnd so it can be returned as HI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= MULT;
            cnt        <= '0;
            opnd       <= '0;
            acc        <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            write_data <= '0;
        end else if (accept) begin
            op_q     <= md_op_t'(op);
            cnt      <= '0;
            neg_q    <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_r    <= (md_op_t'(op) == DIV) && src_a[WIDTH-1];
            div_zero <= op[1] && (src_b == '0);
            if (op[1]) begin
                opnd <= (src_b == '0) ? src_a : mag_b;
                acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
                opnd <= mag_a;
                acc  <= {{WIDTH{1'b0}}, mag_b};
            end
        end else if (state == CALC) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_next;
            if (last && !flush) write_data <= result;
        end
    end

endmodule

// File: tb/tb_mult_div_engine.sv
// Scoreboard bench for mult_div_engine: cycle-exact busy/write timing and reference-model results.
module tb_mult_div_engine;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush;
    logic        busy, write;
    logic [63:0] write_data;

    int          n_tests;
    int          n_fail;
    logic [63:0] sb[$];
    logic [63:0] last_wd;

    mult_div_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .busy       (busy),
        .write      (write),
        .write_data (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_v, q, r, p;
        longint unsigned ua, ub, up;
        sa   = {{32{a[31]}}, a};
        sb_v = {{32{b[31]}}, b};
        ua   = {32'b0, a};
        ub   = {32'b0, b};
        case (o)
            2'd0: begin p = sa * sb_v; return p; end
            2'd1: begin up = ua * ub; return up; end
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_v;
                r = sa % sb_v;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                up = ua / ub;
                ua = ua % ub;
                return {ua[31:0], up[31:0]};
            end
        endcase
    endfunction

    // Call just after a rising edge: drives the request for the current cycle (cycle 0).
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit expect_it);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (expect_it) sb.push_back(model(o, a, b));
    endtask

    // Follows cycles 1..33 after an issue; optional disturbing start/flush at given cycles.
    task automatic watch_op(input string name, input int start_at, input int flush_at);
        logic exp_busy, exp_write;
        logic [63:0] exp_wd;
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            flush = 1'b0;
            if (c == start_at) begin
                start = 1'b1;
                op    = 2'd1;
                src_a = 32'h1234_5678;
                src_b = 32'h0000_0003;
            end
            if (c == flush_at) flush = 1'b1;
            @(negedge clk);
            exp_busy  = !(flush_at > 0 && c > flush_at);
            exp_write = (c == 33) && (flush_at == 0 || flush_at >= 33);
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL %s busy cycle %0d: got %b want %b", name, c, busy, exp_busy);
            end
            n_tests++;
            if (write !== exp_write) begin
                n_fail++;
                $display("FAIL %s write cycle %0d: got %b want %b", name, c, write, exp_write);
            end
            if (write === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s unexpected write cycle %0d data %h", name, c, write_data);
                end else begin
                    exp_wd = sb.pop_front();
                    n_tests++;
                    if (write_data !== exp_wd) begin
                        n_fail++;
                        $display("FAIL %s write_data: got %h want %h", name, write_data, exp_wd);
                    end
                    last_wd = exp_wd;
                end
            end else begin
                n_tests++;
                if (write_data !== last_wd) begin
                    n_fail++;
                    $display("FAIL %s write_data held cycle %0d: got %h want %h", name, c, write_data, last_wd);
                end
            end
        end
        start = 1'b0;
        flush = 1'b0;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s timeout: %0d results never written", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || write !== 1'b0 || write_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b write=%b wd=%h want 0/0/0", busy, write, write_data);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        last_wd = 64'd0;
    endtask

    task automatic test_mult();
        @(posedge clk); #1; issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1); watch_op("multu_max", 0, 0);
        @(posedge clk); #1; issue(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b1);       watch_op("mult_neg", 0, 0);
        @(posedge clk); #1; issue(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b1); watch_op("mult_min", 0, 0);
    endtask

    task automatic test_div();
        @(posedge clk); #1; issue(2'd3, 32'd100, 32'd7, 1'b1);               watch_op("divu", 0, 0);
        @(posedge clk); #1; issue(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);         watch_op("div_neg", 0, 0);
        @(posedge clk); #1; issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1); watch_op("div_ovf", 0, 0);
        @(posedge clk); #1; issue(2'd3, 32'd5, 32'd0, 1'b1);                 watch_op("divu_zero", 0, 0);
        @(posedge clk); #1; issue(2'd2, 32'hFFFF_FFF0, 32'd0, 1'b1);         watch_op("div_zero", 0, 0);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 8; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            @(posedge clk); #1; issue(o, a, b, 1'b1); watch_op("random", 0, 0);
        end
    endtask

    task automatic test_start_ignored();
        @(posedge clk); #1; issue(2'd0, 32'd1000, 32'hFFFF_FF00, 1'b1); watch_op("start_busy", 10, 0);
    endtask

    task automatic test_flush();
        @(posedge clk); #1; issue(2'd3, 32'd77, 32'd5, 1'b0); watch_op("flush_calc", 0, 10);
        @(posedge clk); #1; issue(2'd1, 32'd9, 32'd9, 1'b1);  watch_op("flush_done", 0, 33);
        @(posedge clk);
        #1;
        start = 1'b1;
        flush = 1'b1;
        op    = 2'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if (busy !== 1'b0 || write !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_idle: busy=%b write=%b want 0/0", busy, write);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1; issue(2'd1, 32'd6, 32'd7, 1'b1); watch_op("b2b_first", 0, 0);
        @(posedge clk);
        #1;
        issue(2'd2, 32'd50, 32'hFFFF_FFFA, 1'b1);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || write !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle cycle 34: busy=%b write=%b want 0/0", busy, write);
        end
        watch_op("b2b_second", 0, 0);
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1; issue(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || write !== 1'b0 || write_data !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b write=%b wd=%h want 0/0/0", busy, write, write_data);
        end
        last_wd = 64'd0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1; issue(2'd1, 32'd2, 32'd3, 1'b1); watch_op("after_reset", 0, 0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        last_wd = 64'd0;
        start   = 1'b0;
        flush   = 1'b0;
        op      = 2'd0;
        src_a   = 32'd0;
        src_b   = 32'd0;
        rst     = 1'b1;
        test_reset();
        test_mult();
        test_div();
        test_start_ignored();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
